fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// Sequences instruction fetch for the pipelined MIPS core: owns the fetch PC,
// issues requests to the synchronous instruction ROM, and buffers returned words
// in a small fetch queue. Sits between the NPC/branch logic (redirects) and the
// decode stage (valid/ready consumer). Handles back-pressure, flush on redirect and halt.
// PARAMETERS
// RESET_PC  32'h0000_3000  fetch PC loaded on reset
// IM_AW     10             ROM word-address width (1024 words)
// FQ_DEPTH  2              fetch-queue entries (power of 2, >=2)
// PORTS
// clk           in   1      clock, rising edge
// reset         in   1      synchronous, active-high
// redir_valid   in   1      redirect request (branch/jump/jr resolved)
// redir_pc      in   32     redirect target
// halt          in   1      level: stop issuing new fetches
// imem_req      out  1      ROM read strobe this cycle
// imem_addr     out  IM_AW  ROM word address = pc[IM_AW+1:2]
// imem_rdata    in   32     ROM data, valid the cycle after imem_req
// if_valid      out  1      queue head valid to decode
// if_instr      out  32     queue head instruction
// if_pc         out  32     PC of queue head
// if_ready      in   1      decode accepts head (fire = if_valid & if_ready)
// pc_align_err  out  1      1-cycle pulse: redir_pc[1:0] != 0
// fq_count      out  $clog2(FQ_DEPTH)+1  current queue occupancy
// BEHAVIOUR
// - Reset (sync): pc=RESET_PC, queue empty, no in-flight, state RUN; all outputs 0
//   except imem_addr=RESET_PC[IM_AW+1:2]. Reset dominates every other input.
// - FSM: RUN (issue allowed), HOLD (halt=1, no issue), FLUSH (1 cycle after redirect).
//   RUN->HOLD when halt=1; HOLD->RUN when halt=0; any->FLUSH on redir_valid;
//   FLUSH->RUN (or HOLD if halt=1). Redirect takes priority over halt.
// - Issue: imem_req=1 in RUN iff fq_count + inflight + (fire?-1:0) < FQ_DEPTH
//   and !redir_valid. On issue pc<=pc+4; inflight<=1 with tag pc.
// - Return: cycle after issue, if in-flight not killed, {imem_rdata, tag} written
//   to queue tail at end of cycle; if_valid visible next cycle (no bypass).
// - Latency: request cycle t -> if_valid at t+2. After reset release, first
//   if_valid with if_pc=RESET_PC in cycle 2.
// - Redirect in cycle t: queue cleared, in-flight killed (its data dropped),
//   pc<=redir_pc & ~3 at end of t; FLUSH in t+1 issues redir target; if_valid at t+3.
//   A fire in cycle t is still a valid handshake; the entry is simply consumed.
// - pc_align_err asserted in the cycle after redir_valid with redir_pc[1:0]!=0.
// - Full queue: no issue; pc holds. Simultaneous fire + return: count unchanged,
//   head advances, tail written. Empty queue + fire never occurs (if_valid=0).
// - Halt: in-flight completes into queue; queue drains normally via if_ready.
// - pc wraps modulo 2^32 on +4; imem_addr truncates to IM_AW bits (ROM aliasing).
// - Queue pointers wrap modulo FQ_DEPTH; fq_count never exceeds FQ_DEPTH.
// - Outputs if_instr/if_pc hold stable while if_valid=1 and if_ready=0.
// TESTING
// 1 Reset released, if_ready=1 always -> if_pc 3000,3004,3008... one per cycle from cycle 2.
// 2 if_ready=0 for 6 cycles -> fq_count saturates at 2, imem_req=0, head if_pc=3000 held.
// 3 redir_valid with redir_pc=32'h3040 while queue full -> queue cleared, next if_valid
//   3 cycles later with if_pc=3040, no stale 3008/300C delivered.
// 4 redir_pc=32'h3042 -> pc_align_err pulse 1 cycle, fetch resumes at 3040.
// 5 halt=1 for 4 cycles with if_ready=1 -> in-flight word delivered, then if_valid=0;
//   halt=0 -> fetch resumes at next sequential pc, no skipped/duplicated address.
// 6 reset asserted mid-stream with queue non-empty -> next cycle if_valid=0,
//   fq_count=0; sequence restarts at 3000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, issues synchronous ROM reads
// and buffers returned words in a small queue feeding decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 10,
  parameter int          FQ_DEPTH = 2,
  localparam int         PW       = $clog2(FQ_DEPTH),
  localparam int         CW       = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redir_valid,
  input  logic [31:0]      redir_pc,
  input  logic             halt,
  output logic             imem_req,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  input  logic             if_ready,
  output logic             pc_align_err,
  output logic [CW-1:0]    fq_count
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   tag_q;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          align_err_q;
  logic [31:0]   instr_mem [FQ_DEPTH];
  logic [31:0]   pc_mem    [FQ_DEPTH];

  logic          fire, wr, issue_ok;
  logic [CW:0]   occ, lim;

  always_comb begin
    state_d = state_q;
    if (redir_valid) state_d = FLUSH;
    else begin
      case (state_q)
        RUN, HOLD, FLUSH: state_d = halt ? HOLD : RUN;
        default:          state_d = RUN;
      endcase
    end
  end

  assign fire     = if_valid & if_ready;
  // A return landing during a redirect belongs to the old stream: drop it.
  assign wr       = inflight_q & ~redir_valid;
  assign issue_ok = (state_q == RUN) || (state_q == FLUSH);
  // Occupancy seen by the next issue: queued + returning - leaving this cycle.
  assign occ      = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign lim      = (CW+1)'(FQ_DEPTH) + (CW+1)'(fire);
  assign imem_req = ~reset & issue_ok & ~redir_valid & (occ < lim);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_err_q <= redir_valid & (|redir_pc[1:0]);
      if (redir_valid) begin
        pc_q       <= redir_pc & ~32'h3;
        inflight_q <= 1'b0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        inflight_q <= imem_req;
        if (imem_req) begin
          pc_q  <= pc_q + 32'd4;
          tag_q <= pc_q;
        end
        if (wr)   tail_q <= tail_q + PW'(1);
        if (fire) head_q <= head_q + PW'(1);
        count_q <= count_q + CW'(wr) - CW'(fire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr) begin
      instr_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]    <= tag_q;
    end
  end

  assign imem_addr    = pc_q[IM_AW+1:2];
  assign if_valid     = (count_q != '0);
  assign if_instr     = if_valid ? instr_mem[head_q] : 32'h0;
  assign if_pc        = if_valid ? pc_mem[head_q] : 32'h0;
  assign pc_align_err = align_err_q;
  assign fq_count     = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a synchronous ROM model whose word
// contents are a known function of the address.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, redir_valid, halt, if_ready;
  logic [31:0] redir_pc;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        pc_align_err;
  logic [1:0]  fq_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .pc_align_err(pc_align_err), .fq_count(fq_count)
  );

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return {22'h0, a} ^ 32'hDEAD_0000;
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= rom_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Leaves the bench at cycle 0: first cycle with reset low.
  task automatic do_reset();
    reset = 1'b1; redir_valid = 1'b0; redir_pc = '0; halt = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  logic [31:0] exp_pc;
  int          fires;

  initial begin
    imem_rdata = '0;
    reset = 1'b1; redir_valid = 1'b0; redir_pc = '0; halt = 1'b0; if_ready = 1'b1;

    // Reset state
    cyc(); mid();
    check("rst_req",   {31'h0, imem_req}, 32'h0);
    check("rst_addr",  {22'h0, imem_addr}, 32'h0);
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_count", {30'h0, fq_count}, 32'h0);
    check("rst_align", {31'h0, pc_align_err}, 32'h0);
    check("rst_pc",    if_pc, 32'h0);

    // 1: streaming, one word per cycle from cycle 2
    do_reset(); if_ready = 1'b1;
    mid();
    check("c0_req",   {31'h0, imem_req}, 32'h1);
    check("c0_valid", {31'h0, if_valid}, 32'h0);
    cyc(); mid();
    check("c1_addr",  {22'h0, imem_addr}, 32'h1);
    check("c1_valid", {31'h0, if_valid}, 32'h0);
    cyc(); mid();
    check("c2_valid", {31'h0, if_valid}, 32'h1);
    check("c2_pc",    if_pc, 32'h3000);
    check("c2_instr", if_instr, 32'hDEAD_0000);
    cyc(); mid();
    check("c3_pc",    if_pc, 32'h3004);
    cyc(); mid();
    check("c4_pc",    if_pc, 32'h3008);
    check("c4_instr", if_instr, 32'hDEAD_0002);

    // 2: back-pressure, queue saturates
    do_reset(); if_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mid();
      if (c == 2) check("bp_c2_count", {30'h0, fq_count}, 32'h1);
      if (c == 3) check("bp_c3_count", {30'h0, fq_count}, 32'h2);
      if (c == 5) begin
        check("bp_count", {30'h0, fq_count}, 32'h2);
        check("bp_req",   {31'h0, imem_req}, 32'h0);
        check("bp_pc",    if_pc, 32'h3000);
        check("bp_valid", {31'h0, if_valid}, 32'h1);
      end
      cyc();
    end

    // 3: redirect with full queue (cycle t = 6)
    redir_valid = 1'b1; redir_pc = 32'h3040;
    mid();
    check("rd_t_req", {31'h0, imem_req}, 32'h0);
    cyc(); redir_valid = 1'b0; if_ready = 1'b1;
    mid();
    check("rd_t1_count", {30'h0, fq_count}, 32'h0);
    check("rd_t1_valid", {31'h0, if_valid}, 32'h0);
    check("rd_t1_req",   {31'h0, imem_req}, 32'h1);
    check("rd_t1_addr",  {22'h0, imem_addr}, 32'h10);
    check("rd_t1_align", {31'h0, pc_align_err}, 32'h0);
    cyc(); mid();
    check("rd_t2_valid", {31'h0, if_valid}, 32'h0);
    cyc(); mid();
    check("rd_t3_valid", {31'h0, if_valid}, 32'h1);
    check("rd_t3_pc",    if_pc, 32'h3040);
    check("rd_t3_instr", if_instr, 32'hDEAD_0010);
    cyc(); mid();
    check("rd_t4_pc",    if_pc, 32'h3044);
    cyc();

    // 4: misaligned redirect
    redir_valid = 1'b1; redir_pc = 32'h3042;
    mid(); cyc(); redir_valid = 1'b0;
    mid();
    check("al_pulse", {31'h0, pc_align_err}, 32'h1);
    check("al_addr",  {22'h0, imem_addr}, 32'h10);
    cyc(); mid();
    check("al_clear", {31'h0, pc_align_err}, 32'h0);
    cyc(); mid();
    check("al_pc",    if_pc, 32'h3040);
    check("al_valid", {31'h0, if_valid}, 32'h1);

    // 5: halt cycles 5..8, then resume with no skip/duplicate
    do_reset(); if_ready = 1'b1;
    exp_pc = 32'h3000; fires = 0;
    for (int c = 0; c <= 16; c++) begin
      halt = (c >= 5 && c <= 8);
      mid();
      if (c >= 8 && c <= 11) check("halt_idle", {31'h0, if_valid}, 32'h0);
      if (c == 12) check("halt_resume", {31'h0, if_valid}, 32'h1);
      if (if_valid) begin
        check("halt_seq", if_pc, exp_pc);
        exp_pc += 32'd4;
        fires++;
      end
      cyc();
    end
    halt = 1'b0;
    check("halt_fires", fires, 32'd11);
    check("halt_last",  exp_pc, 32'h302C);

    // 6: reset mid-stream with a non-empty queue
    do_reset(); if_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mid();
      if (c == 3) check("mr_full", {30'h0, fq_count}, 32'h2);
      cyc();
    end
    reset = 1'b1;
    mid();
    check("mr_rst_req", {31'h0, imem_req}, 32'h0);
    cyc(); reset = 1'b0;
    mid();
    check("mr_valid", {31'h0, if_valid}, 32'h0);
    check("mr_count", {30'h0, fq_count}, 32'h0);
    check("mr_req",   {31'h0, imem_req}, 32'h1);
    cyc(); cyc(); if_ready = 1'b1;
    mid();
    check("mr_pc",    if_pc, 32'h3000);
    check("mr_instr", if_instr, 32'hDEAD_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
